// File: rtl/cve2_pkg.sv
// Shared types for the MAC accumulate unit: ALU operation codes and FSM states.
package cve2_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_MUL = 2'd1,
        ALU_MAC = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        MAC_IDLE = 2'd0,
        MAC_MUL  = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_DONE = 2'd3
    } mac_acc_state_e;

endpackage

// File: rtl/cve2_mac_acc_unit.sv
// Multi-cycle multiply-accumulate (a*b + c) sequenced over the shared ALU:
// one cycle multiplying, one cycle adding, one cycle presenting the result.
module cve2_mac_acc_unit
    import cve2_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mac_valid_i,
    output logic             mac_ready_o,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic [Width-1:0] op_c_i,
    input  logic             flush_i,
    output alu_op_e          alu_operator_o,
    output logic [Width-1:0] alu_operand_a_o,
    output logic [Width-1:0] alu_operand_b_o,
    input  logic [Width-1:0] alu_result_i,
    output logic [Width-1:0] mac_result_o,
    output logic             mac_result_valid_o,
    output logic             stall_o
);

    mac_acc_state_e state_q, state_d;
    logic [Width-1:0] op_a_q, op_b_q, op_c_q;
    logic [Width-1:0] product_q, sum_q;
    logic             accept;

    assign accept = (state_q == MAC_IDLE) && mac_valid_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= MAC_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_c_q    <= '0;
            product_q <= '0;
            sum_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q <= op_a_i;
                op_b_q <= op_b_i;
                op_c_q <= op_c_i;
            end
            // A flushed step must not disturb the last completed sum.
            if (state_q == MAC_MUL && !flush_i) product_q <= alu_result_i;
            if (state_q == MAC_ADD && !flush_i) sum_q     <= alu_result_i;
        end
    end

    always_comb begin
        state_d            = state_q;
        alu_operator_o     = ALU_ADD;
        alu_operand_a_o    = '0;
        alu_operand_b_o    = '0;
        mac_ready_o        = 1'b0;
        mac_result_valid_o = 1'b0;
        stall_o            = 1'b0;

        case (state_q)
            MAC_IDLE: begin
                mac_ready_o = 1'b1;
                stall_o     = mac_valid_i && !flush_i;
                if (accept) state_d = MAC_MUL;
            end
            MAC_MUL: begin
                alu_operator_o  = ALU_MUL;
                alu_operand_a_o = op_a_q;
                alu_operand_b_o = op_b_q;
                stall_o         = 1'b1;
                state_d         = flush_i ? MAC_IDLE : MAC_ADD;
            end
            MAC_ADD: begin
                alu_operator_o  = ALU_ADD;
                alu_operand_a_o = product_q;
                alu_operand_b_o = op_c_q;
                stall_o         = 1'b1;
                state_d         = flush_i ? MAC_IDLE : MAC_DONE;
            end
            MAC_DONE: begin
                mac_result_valid_o = !flush_i;
                state_d            = MAC_IDLE;
            end
            default: state_d = MAC_IDLE;
        endcase

        // While reset is held the state register may not yet be IDLE, so
        // force the idle-looking outputs directly.
        if (!rst_ni) begin
            alu_operator_o     = ALU_ADD;
            alu_operand_a_o    = '0;
            alu_operand_b_o    = '0;
            mac_ready_o        = 1'b1;
            mac_result_valid_o = 1'b0;
            stall_o            = mac_valid_i;
        end
    end

    assign mac_result_o = rst_ni ? sum_q : '0;

endmodule

// File: tb/tb_cve2_mac_acc_unit.sv
// Self-checking bench for cve2_mac_acc_unit with a behavioural shared ALU.
module tb_cve2_mac_acc_unit;
    import cve2_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mac_valid_i;
    logic        mac_ready_o;
    logic [31:0] op_a_i, op_b_i, op_c_i;
    logic        flush_i;
    alu_op_e     alu_operator_o;
    logic [31:0] alu_operand_a_o, alu_operand_b_o, alu_result_i;
    logic [31:0] mac_result_o;
    logic        mac_result_valid_o;
    logic        stall_o;

    cve2_mac_acc_unit #(.Width(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i), .flush_i(flush_i),
        .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
        .alu_operand_b_o(alu_operand_b_o), .alu_result_i(alu_result_i),
        .mac_result_o(mac_result_o), .mac_result_valid_o(mac_result_valid_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        alu_result_i = 32'h0;
        case (alu_operator_o)
            ALU_MUL: alu_result_i = alu_operand_a_o * alu_operand_b_o;
            ALU_ADD: alu_result_i = alu_operand_a_o + alu_operand_b_o;
            default: alu_result_i = 32'h0;
        endcase
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && mac_result_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                check("sb_result", mac_result_o, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [31:0] a, b, c;
        logic [31:0] exp;
        bit          scramble;
    } vec_t;

    vec_t vecs[6];
    int   pulse_cyc;

    // Present a request in IDLE and let it be accepted on the next edge.
    task automatic start(input logic [31:0] a, b, c, input bit push, input logic [31:0] exp);
        @(negedge clk_i);
        mac_valid_i = 1'b1;
        op_a_i = a; op_b_i = b; op_c_i = c;
        #1;
        check("idle_ready", 32'(mac_ready_o), 32'd1);
        check("idle_stall", 32'(stall_o), 32'd1);
        @(posedge clk_i);
        if (push) exp_q.push_back(exp);
    endtask

    task automatic run_mac(input logic [31:0] a, b, c, exp, input bit scramble);
        logic [31:0] prod;
        prod = a * b;
        start(a, b, c, 1'b1, exp);
        if (scramble) begin
            #1; op_a_i = $urandom; op_b_i = $urandom; op_c_i = $urandom;
        end
        @(negedge clk_i);
        check("mul_op", 32'(alu_operator_o), 32'(ALU_MUL));
        check("mul_a", alu_operand_a_o, a);
        check("mul_b", alu_operand_b_o, b);
        check("mul_stall", 32'(stall_o), 32'd1);
        check("mul_ready", 32'(mac_ready_o), 32'd0);
        if (scramble) begin
            @(posedge clk_i); #1; op_a_i = $urandom; op_b_i = $urandom; op_c_i = $urandom;
        end
        @(negedge clk_i);
        check("add_op", 32'(alu_operator_o), 32'(ALU_ADD));
        check("add_a", alu_operand_a_o, prod);
        check("add_b", alu_operand_b_o, c);
        check("add_valid", 32'(mac_result_valid_o), 32'd0);
        @(negedge clk_i);
        check("done_valid", 32'(mac_result_valid_o), 32'd1);
        check("done_result", mac_result_o, exp);
        check("done_stall", 32'(stall_o), 32'd0);
        check("done_operand_a", alu_operand_a_o, 32'd0);
        pulse_cyc = cyc;
        @(posedge clk_i); #1;
        mac_valid_i = 1'b0;
    endtask

    initial begin
        int prev_cyc;
        logic [31:0] last;
        vecs[0] = '{32'd3, 32'd4, 32'd5, 32'd17, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0000_0001, 1'b0};
        vecs[2] = '{32'd2, 32'd2, 32'd1, 32'd5, 1'b0};
        vecs[3] = '{32'd0, 32'd123, 32'd7, 32'd7, 1'b1};
        vecs[4] = '{32'd10000, 32'd10000, 32'd0, 32'h05F5_E100, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'd2, 32'h10, 32'h10, 1'b1};

        rst_ni = 1'b0; mac_valid_i = 1'b0; flush_i = 1'b0;
        op_a_i = '0; op_b_i = '0; op_c_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", 32'(mac_ready_o), 32'd1);
        check("rst_valid", 32'(mac_result_valid_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_result", mac_result_o, 32'd0);
        check("rst_op", 32'(alu_operator_o), 32'(ALU_ADD));
        rst_ni = 1'b1;

        // Back-to-back table: each request enters the IDLE cycle right after DONE.
        prev_cyc = -1;
        for (int i = 0; i < 6; i++) begin
            run_mac(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, vecs[i].scramble);
            if (prev_cyc >= 0) check("b2b_spacing", 32'(pulse_cyc - prev_cyc), 32'd4);
            prev_cyc = pulse_cyc;
        end
        last = vecs[5].exp;

        // Result holds while idle.
        repeat (2) @(negedge clk_i);
        check("hold_result", mac_result_o, last);

        // Flush in ADD: back to IDLE, no pulse, sum untouched.
        start(32'd6, 32'd7, 32'd8, 1'b0, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; mac_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_add_ready", 32'(mac_ready_o), 32'd1);
        check("flush_add_valid", 32'(mac_result_valid_o), 32'd0);
        check("flush_add_result", mac_result_o, last);
        repeat (3) @(negedge clk_i);
        check("flush_add_quiet", 32'(mac_result_valid_o), 32'd0);

        // Flush coincident with DONE: pulse suppressed.
        start(32'd1, 32'd1, 32'd1, 1'b0, 32'd0);
        repeat (3) @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        check("flush_done_valid", 32'(mac_result_valid_o), 32'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; mac_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_done_ready", 32'(mac_ready_o), 32'd1);

        // Reset in MUL: outputs at reset values, no pulse, sum cleared.
        start(32'd9, 32'd9, 32'd9, 1'b0, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rst_mul_ready", 32'(mac_ready_o), 32'd1);
        check("rst_mul_stall", 32'(stall_o), 32'd1);
        check("rst_mul_op", 32'(alu_operator_o), 32'(ALU_ADD));
        check("rst_mul_valid", 32'(mac_result_valid_o), 32'd0);
        @(posedge clk_i); #1;
        mac_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("post_rst_ready", 32'(mac_ready_o), 32'd1);
        check("post_rst_stall", 32'(stall_o), 32'd0);
        check("post_rst_result", mac_result_o, 32'd0);
        repeat (4) @(negedge clk_i);
        check("post_rst_quiet", 32'(mac_result_valid_o), 32'd0);

        // Unit still works after the aborts.
        run_mac(32'd3, 32'd4, 32'd5, 32'd17, 1'b0);
        repeat (2) @(negedge clk_i);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cve2_mac_acc_unit.md
CVE2_MAC_ACC_UNIT -- requirements
Module: cve2_mac_acc_unit

Interface
REQ-001 SHALL have parameter Width, default 32, datapath width of all operands and results.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port mac_valid_i  input  1  MAC request from the decoder, held high until mac_result_valid_o.
REQ-005 SHALL have port mac_ready_o  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port op_a_i  input  Width  multiplicand (rs1).
REQ-007 SHALL have port op_b_i  input  Width  multiplier (rs2).
REQ-008 SHALL have port op_c_i  input  Width  accumulator addend (old rd value).
REQ-009 SHALL have port flush_i  input  1  pipeline flush; aborts any MAC in flight.
REQ-010 SHALL have port alu_operator_o  output  cve2_pkg::alu_op_e  operation requested from the shared ALU.
REQ-011 SHALL have ports alu_operand_a_o and alu_operand_b_o  output  Width each  ALU operands.
REQ-012 SHALL have port alu_result_i  input  Width  combinational ALU result for the current cycle.
REQ-013 SHALL have port mac_result_o  output  Width  final accumulated value.
REQ-014 SHALL have port mac_result_valid_o  output  1  one-cycle register-file write strobe for mac_result_o.
REQ-015 SHALL have port stall_o  output  1  holds the ID stage while a MAC is pending.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, ADD, DONE.
REQ-017 SHALL drive mac_ready_o high only in IDLE.
REQ-018 SHALL accept a request when state is IDLE, mac_valid_i=1, flush_i=0, and on that edge capture op_a_i, op_b_i, op_c_i into internal registers and move to MUL.
REQ-019 SHALL, in MUL, drive ALU_MUL with the captured op_a and op_b, register alu_result_i as product (low Width bits), and move to ADD.
REQ-020 SHALL, in ADD, drive ALU_ADD with operand_a = product and operand_b = captured op_c, register alu_result_i as sum (modulo 2^Width wrap), and move to DONE.
REQ-021 SHALL, in DONE, assert mac_result_valid_o = !flush_i for exactly one cycle with mac_result_o = sum, then move to IDLE unconditionally.
REQ-022 SHALL ignore mac_valid_i in MUL, ADD and DONE; the earliest next acceptance is the cycle after DONE.
REQ-023 SHALL produce mac_result_valid_o exactly 3 cycles after the accept edge (accept at T, MUL at T+1, ADD at T+2, DONE at T+3).
REQ-024 SHALL drive stall_o = (state is MUL or ADD) OR (state is IDLE AND mac_valid_i AND !flush_i); stall_o is 0 in DONE.
REQ-025 SHALL drive alu_operator_o = ALU_ADD and both ALU operands = 0 in IDLE and DONE.
REQ-026 SHALL return to IDLE on the next edge when flush_i=1 in MUL, ADD or DONE, with no mac_result_valid_o pulse for the aborted request.
REQ-027 SHALL hold mac_result_o at the last completed sum until the next DONE.

Reset
REQ-028 SHALL, when rst_ni=0 at a clock edge, set state to IDLE and clear the captured operands, product and sum to 0.
REQ-029 SHALL produce these output values during and after reset: mac_ready_o=1, mac_result_valid_o=0, stall_o=mac_valid_i, mac_result_o=0, alu_operator_o=ALU_ADD.
REQ-030 SHALL abort a MAC in flight when reset is asserted, with no result pulse.

Structure
REQ-031 SHALL take alu_op_e (ALU_MUL, ALU_ADD, ALU_MAC) from cve2_pkg.
REQ-032 SHALL add the state typedef mac_acc_state_e to cve2_pkg.
REQ-033 SHALL be a single flat module with no sub-modules; the multiply and the add both use the shared ALU.

Verification
REQ-034 SHALL cover single MAC: a=3, b=4, c=5 accepted at T -> MUL/ALU_MUL at T+1, ALU_ADD operands (12,5) at T+2, mac_result_valid_o=1 with result 17 at T+3, stall_o low at T+3.
REQ-035 SHALL cover wrap-around: a=0xFFFF_FFFF, b=2, c=3 -> product 0xFFFF_FFFE, result 0x0000_0001.
REQ-036 SHALL cover operand change: op_a/b/c change during MUL and ADD -> result still uses the values captured at accept.
REQ-037 SHALL cover flush: flush_i in ADD -> IDLE next cycle, no valid pulse, mac_ready_o=1; flush_i coincident with DONE -> pulse suppressed.
REQ-038 SHALL cover back-to-back: second request (a=2, b=2, c=1) presented in the cycle after DONE -> accepted, result 5 four cycles after the first result.
REQ-039 SHALL cover reset mid-operation: rst_ni low in MUL -> IDLE, all outputs at reset values, no result pulse.
